// File: rtl/ddk_pbus_seq.sv
// ddk_pbus_seq -- write/read-back sweep master for the DDK parallel register bus.
//
// For every channel from ch_first to ch_last (inclusive) one register at
// {cfg_hi, ch, cfg_reg} is written with cfg_dat, read back after STROBE_GAP
// cycles, and compared after another SETTLE cycles. A mismatch or missing ack
// is retried up to MAX_RETRY times before the channel is counted as failed.
// Bus strobes are toggle-encoded: every level change of dclk_o is one access.
//
// Ports:
//   tb_clk, tb_rst        clock, asynchronous active-high reset
//   start                 one-cycle sweep request (ignored while busy)
//   cfg_hi/cfg_reg/cfg_dat  address MSB, register offset, data for the sweep
//   ch_first/ch_last      inclusive channel range
//   dclk_o/we_o/adr_o/dat_o  bus strobe (DataClk), write enable, address, data
//   ack_i/dat_i           slave acknowledge and read data
//   busy/done             sweep in progress / one-cycle end-of-sweep pulse
//   err_cnt/last_err_ch/pass_ok  results of the last sweep
module ddk_pbus_seq #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int CH_W       = 3,
  parameter int STROBE_GAP = 12,
  parameter int SETTLE     = 3,
  parameter int MAX_RETRY  = 2,
  parameter int ERR_W      = 8
) (
  input  logic                     tb_clk,
  input  logic                     tb_rst,
  input  logic                     start,
  input  logic                     cfg_hi,
  input  logic [ADDR_W-CH_W-2:0]   cfg_reg,
  input  logic [DATA_W-1:0]        cfg_dat,
  input  logic [CH_W-1:0]          ch_first,
  input  logic [CH_W-1:0]          ch_last,
  output logic                     dclk_o,
  output logic                     we_o,
  output logic [ADDR_W-1:0]        adr_o,
  output logic [DATA_W-1:0]        dat_o,
  input  logic                     ack_i,
  input  logic [DATA_W-1:0]        dat_i,
  output logic                     busy,
  output logic                     done,
  output logic [ERR_W-1:0]         err_cnt,
  output logic [CH_W-1:0]          last_err_ch,
  output logic                     pass_ok
);

  localparam int REG_W   = ADDR_W - 1 - CH_W;
  localparam int CNT_MAX = (STROBE_GAP > SETTLE) ? STROBE_GAP : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(STROBE_GAP - 1);
  localparam logic [CNT_W-1:0] SET_LD    = CNT_W'(SETTLE - 1);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, WAIT_W, WAIT_R, CHECK} state_t;

  state_t              state_q;
  logic                hi_q;
  logic [REG_W-1:0]    reg_q;
  logic [DATA_W-1:0]   cfg_dat_q;
  logic [CH_W-1:0]     ch_q, ch_last_q;
  logic [3:0]          retry_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                dclk_q, we_q, busy_q, done_q, pass_ok_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   dat_q;
  logic [ERR_W-1:0]    err_q;
  logic [CH_W-1:0]     last_err_q;

  logic                pass, retry_left;
  logic [ERR_W-1:0]    err_inc, err_fin;
  logic [CH_W-1:0]     ch_inc;

  always_comb begin
    pass       = ack_i && (dat_i == cfg_dat_q);
    // retry_q counts up to MAX_RETRY, so "fewer than MAX_RETRY" is inequality
    retry_left = (retry_q != RETRY_LIM);
    err_inc    = (&err_q) ? err_q : err_q + 1'b1;
    err_fin    = pass ? err_q : err_inc;
    ch_inc     = ch_q + 1'b1;
  end

  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q    <= IDLE;
      hi_q       <= 1'b0;
      reg_q      <= '0;
      cfg_dat_q  <= '0;
      ch_q       <= '0;
      ch_last_q  <= '0;
      retry_q    <= '0;
      cnt_q      <= '0;
      dclk_q     <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      last_err_q <= '0;
      pass_ok_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            hi_q      <= cfg_hi;
            reg_q     <= cfg_reg;
            cfg_dat_q <= cfg_dat;
            ch_last_q <= ch_last;
            ch_q      <= ch_first;
            retry_q   <= '0;
            err_q     <= '0;
            if (ch_first > ch_last) begin
              // empty range: finish on the sampling edge, bus untouched
              done_q    <= 1'b1;
              pass_ok_q <= 1'b1;
            end else begin
              busy_q    <= 1'b1;
              pass_ok_q <= 1'b0;
              adr_q     <= {cfg_hi, ch_first, cfg_reg};
              dat_q     <= cfg_dat;
              we_q      <= 1'b1;
              dclk_q    <= ~dclk_q;
              cnt_q     <= GAP_LD;
              state_q   <= WAIT_W;
            end
          end
        end
        WAIT_W: begin
          if (cnt_q == '0) begin
            we_q    <= 1'b0;
            dclk_q  <= ~dclk_q;
            cnt_q   <= SET_LD;
            state_q <= WAIT_R;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WAIT_R: begin
          if (cnt_q == '0) state_q <= CHECK;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        CHECK: begin
          if (!pass && retry_left) begin
            retry_q <= retry_q + 1'b1;
            adr_q   <= {hi_q, ch_q, reg_q};
            dat_q   <= cfg_dat_q;
            we_q    <= 1'b1;
            dclk_q  <= ~dclk_q;
            cnt_q   <= GAP_LD;
            state_q <= WAIT_W;
          end else begin
            if (!pass) begin
              err_q      <= err_inc;
              last_err_q <= ch_q;
            end
            // compare against ch_last rather than wrapping, so a range ending
            // at the top channel index still terminates
            if (ch_q == ch_last_q) begin
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              pass_ok_q <= (err_fin == '0);
              state_q   <= IDLE;
            end else begin
              ch_q    <= ch_inc;
              retry_q <= '0;
              adr_q   <= {hi_q, ch_inc, reg_q};
              dat_q   <= cfg_dat_q;
              we_q    <= 1'b1;
              dclk_q  <= ~dclk_q;
              cnt_q   <= GAP_LD;
              state_q <= WAIT_W;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dclk_o      = dclk_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_cnt     = err_q;
  assign last_err_ch = last_err_q;
  assign pass_ok     = pass_ok_q;

endmodule

// File: tb/tb_ddk_pbus_seq.sv
// Directed bench for ddk_pbus_seq: loopback slave with fault modes on the
// default instance, and a never-acking slave on a MAX_RETRY=0 instance.
module tb_ddk_pbus_seq;

  logic       tb_clk = 1'b0;
  logic       tb_rst = 1'b1;
  always #5 tb_clk = ~tb_clk;

  logic       start = 1'b0, start2 = 1'b0;
  logic       cfg_hi = 1'b0;
  logic [3:0] cfg_reg = '0;
  logic [7:0] cfg_dat = '0;
  logic [2:0] ch_first = '0, ch_last = '0, ch_first2 = '0, ch_last2 = '0;

  logic       dclk, we, busy, done, pass_ok, ack;
  logic [7:0] adr, dat_o, dat_i, err_cnt;
  logic [2:0] last_err_ch;

  logic       dclk2, we2, busy2, done2, pass_ok2;
  logic [7:0] adr2, dat_o2, err_cnt2;
  logic [2:0] last_err_ch2;

  ddk_pbus_seq dut (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .start(start), .cfg_hi(cfg_hi),
    .cfg_reg(cfg_reg), .cfg_dat(cfg_dat), .ch_first(ch_first), .ch_last(ch_last),
    .dclk_o(dclk), .we_o(we), .adr_o(adr), .dat_o(dat_o), .ack_i(ack), .dat_i(dat_i),
    .busy(busy), .done(done), .err_cnt(err_cnt), .last_err_ch(last_err_ch),
    .pass_ok(pass_ok)
  );

  ddk_pbus_seq #(.MAX_RETRY(0)) dut2 (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .start(start2), .cfg_hi(cfg_hi),
    .cfg_reg(cfg_reg), .cfg_dat(cfg_dat), .ch_first(ch_first2), .ch_last(ch_last2),
    .dclk_o(dclk2), .we_o(we2), .adr_o(adr2), .dat_o(dat_o2), .ack_i(1'b0),
    .dat_i(8'h00), .busy(busy2), .done(done2), .err_cnt(err_cnt2),
    .last_err_ch(last_err_ch2), .pass_ok(pass_ok2)
  );

  // Slave model: latches written data on a write toggle, returns it on reads.
  // mode 1: channel 2 always reads 0xFF; mode 2: first read of channel 1 is inverted.
  int         cyc = 0, toggles = 0, ch1_reads = 0, ch1_base = 0, mode = 0;
  logic       dclk_prev = 1'b0;
  logic [7:0] mem = '0;
  logic [7:0] wadr[$];

  always @(posedge tb_clk) begin
    cyc       <= cyc + 1;
    dclk_prev <= dclk;
    if (dclk != dclk_prev) begin
      toggles <= toggles + 1;
      if (we) begin
        mem <= dat_o;
        wadr.push_back(adr);
      end else if (adr[6:4] == 3'd1) begin
        ch1_reads <= ch1_reads + 1;
      end
    end
  end

  always_comb begin
    ack   = 1'b1;
    dat_i = mem;
    if (mode == 1 && adr[6:4] == 3'd2) dat_i = 8'hFF;
    if (mode == 2 && adr[6:4] == 3'd1 && (ch1_reads - ch1_base) == 1) dat_i = ~mem;
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts one sweep on dut, scrambles cfg_* afterwards (must be ignored),
  // and waits (bounded) for done. elapsed = -1 if done never came.
  task automatic run1(input logic hi, input logic [3:0] rg, input logic [7:0] d,
                      input logic [2:0] f, input logic [2:0] l,
                      output int elapsed, output logic busy_at_t);
    int t0;
    @(negedge tb_clk);
    cfg_hi = hi; cfg_reg = rg; cfg_dat = d; ch_first = f; ch_last = l; start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    cfg_hi = ~hi; cfg_reg = ~rg; cfg_dat = ~d;
    t0 = cyc;
    busy_at_t = busy;
    elapsed = -1;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        elapsed = cyc - t0;
        break;
      end
      @(negedge tb_clk);
    end
  endtask

  int   el, tog0, wa0, t0;
  logic bz, saw_done;

  initial begin
    repeat (3) @(negedge tb_clk);
    check("rst_dclk", dclk, 0);   check("rst_we", we, 0);
    check("rst_adr", adr, 0);     check("rst_dat", dat_o, 0);
    check("rst_busy", busy, 0);   check("rst_done", done, 0);
    check("rst_err", err_cnt, 0); check("rst_lastch", last_err_ch, 0);
    check("rst_passok", pass_ok, 0);
    tb_rst = 1'b0;

    // all-pass sweep, channels 0..3; address = {hi, ch[2:0], reg[3:0]}
    mode = 0; tog0 = toggles; wa0 = wadr.size();
    run1(1'b1, 4'd5, 8'h01, 3'd0, 3'd3, el, bz);
    check("t1_busy", bz, 1);
    check("t1_done_at", el, 64);
    check("t1_toggles", toggles - tog0, 8);
    check("t1_adr0", wadr[wa0],   8'h85);
    check("t1_adr1", wadr[wa0+1], 8'h95);
    check("t1_adr2", wadr[wa0+2], 8'hA5);
    check("t1_adr3", wadr[wa0+3], 8'hB5);
    check("t1_err", err_cnt, 0);
    check("t1_passok", pass_ok, 1);
    @(negedge tb_clk);
    check("t1_done_pulse", done, 0);
    check("t1_busy_end", busy, 0);

    // empty range: immediate done, no bus activity
    tog0 = toggles;
    run1(1'b0, 4'd1, 8'h22, 3'd5, 3'd3, el, bz);
    check("t5_done_at", el, 0);
    check("t5_busy", bz, 0);
    check("t5_passok", pass_ok, 1);
    repeat (2) @(negedge tb_clk);
    check("t5_toggles", toggles - tog0, 0);

    // first read of ch1 corrupted: one retry, still passes
    mode = 2; ch1_base = ch1_reads; tog0 = toggles;
    run1(1'b0, 4'd2, 8'h5A, 3'd0, 3'd3, el, bz);
    check("t3_done_at", el, 80);
    check("t3_toggles", toggles - tog0, 10);
    check("t3_err", err_cnt, 0);
    check("t3_passok", pass_ok, 1);

    // ch2 always wrong: 3 attempts then counted as failed
    mode = 1; tog0 = toggles;
    run1(1'b1, 4'd5, 8'h3F, 3'd0, 3'd3, el, bz);
    check("t2_done_at", el, 96);
    check("t2_toggles", toggles - tog0, 12);
    check("t2_err", err_cnt, 1);
    check("t2_lastch", last_err_ch, 2);
    check("t2_passok", pass_ok, 0);

    // reset during WAIT_W of ch1 (ch1 write issued 16 edges after start)
    mode = 0;
    @(negedge tb_clk);
    cfg_hi = 1'b1; cfg_reg = 4'd5; cfg_dat = 8'h01; ch_first = 3'd0; ch_last = 3'd3;
    start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    repeat (20) @(negedge tb_clk);
    check("r_pre_busy", busy, 1);
    check("r_pre_we", we, 1);
    #1 tb_rst = 1'b1;
    #1;
    check("r_dclk", dclk, 0);     check("r_we", we, 0);
    check("r_adr", adr, 0);       check("r_dat", dat_o, 0);
    check("r_busy", busy, 0);     check("r_err", err_cnt, 0);
    check("r_lastch", last_err_ch, 0); check("r_passok", pass_ok, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge tb_clk);
      if (i == 3) tb_rst = 1'b0;
      if (done) saw_done = 1'b1;
    end
    check("r_no_done", saw_done, 0);
    check("r_idle_busy", busy, 0);
    tog0 = toggles;
    run1(1'b1, 4'd5, 8'h01, 3'd0, 3'd3, el, bz);
    check("r_clean_done_at", el, 64);
    check("r_clean_toggles", toggles - tog0, 8);
    check("r_clean_err", err_cnt, 0);
    check("r_clean_passok", pass_ok, 1);

    // MAX_RETRY=0 instance, slave never acks, full range incl. top channel
    @(negedge tb_clk);
    ch_first2 = 3'd0; ch_last2 = 3'd7; start2 = 1'b1;
    @(negedge tb_clk);
    start2 = 1'b0;
    t0 = cyc; el = -1;
    for (int i = 0; i < 400; i++) begin
      if (done2) begin
        el = cyc - t0;
        break;
      end
      @(negedge tb_clk);
    end
    check("t4_done_at", el, 128);
    check("t4_err", err_cnt2, 8);
    check("t4_lastch", last_err_ch2, 7);
    check("t4_passok", pass_ok2, 0);
    check("t4_busy", busy2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
